// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event encoder: channel geometry, the
// snapshot record, output word layout and serialiser states.
package edge_event_pkg;

  localparam int NUM_CH       = 65;
  localparam int CH_WIDTH     = 7;
  localparam int TS_MAX_WIDTH = 48;
  localparam int TDATA_WIDTH  = 64;

  // Output word layout: {1'b0, ch[6:0], 8'd0, ts[47:0]}
  localparam int TD_TS_LSB = 0;
  localparam int TD_CH_LSB = 56;

  // One captured cycle: which enabled channels fired and when.
  typedef struct packed {
    logic [NUM_CH-1:0]       mask;
    logic [TS_MAX_WIDTH-1:0] ts;
  } snapshot_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index of the lowest set bit; scanning downwards lets the lowest win.
  function automatic logic [CH_WIDTH-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CH_WIDTH'(i);
    end
  endfunction

  function automatic logic [TDATA_WIDTH-1:0] pack_word(input logic [CH_WIDTH-1:0]     ch,
                                                       input logic [TS_MAX_WIDTH-1:0] ts);
    pack_word = '0;
    pack_word[TD_CH_LSB +: CH_WIDTH]     = ch;
    pack_word[TD_TS_LSB +: TS_MAX_WIDTH] = ts;
  endfunction

endpackage

// File: rtl/edge_event_fifo.sv
// Snapshot FIFO: DEPTH entries (power of 2, >= 2), full/empty flags.
// The head entry is read straight out of the storage registers, so a pop
// and the consumer's load of the head happen in the same cycle.
// A push while full is accepted only when a pop frees a slot that cycle.
module edge_event_fifo
  import edge_event_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      aclk,
  input  logic      aresetn,
  input  logic      push,
  input  logic      pop,
  input  snapshot_t wr_data,
  output snapshot_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  snapshot_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge aclk) begin
    // NOTE: storage is not reset; pointers and count guarantee stale entries are never read.
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/edge_event_encoder.sv
// Edge event encoder: timestamps cycles in which enabled channels fire,
// buffers the snapshots and serialises them into one AXI4-Stream word per
// fired channel, lowest channel first.
// Optional feature macro: EDGE_EVENT_TLAST_EN (tlast marks the last word of
// each snapshot); when undefined m_axis_tlast is tied 0.
module edge_event_encoder
  import edge_event_pkg::*;
#(
  parameter int TS_WIDTH   = 48,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_CH-1:0]      din,
  input  logic [NUM_CH-1:0]      cfg_mask,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   sts_overflow,
  output logic [15:0]            sts_drops
);

  logic [TS_WIDTH-1:0]     ts_cnt;
  logic [TS_MAX_WIDTH-1:0] ts_ext;
  snapshot_t               cap;
  logic                    cap_hit;
  snapshot_t               fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    drop;
  state_t                  state;
  state_t                  state_nxt;
  snapshot_t               work;
  snapshot_t               work_nxt;
  logic [NUM_CH-1:0]       work_clr;
  logic                    last_word;
  logic [CH_WIDTH-1:0]     ch;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  // Zero-extend the counter into the fixed-width timestamp field.
  always_comb begin
    ts_ext                 = '0;
    ts_ext[TS_WIDTH-1:0] = ts_cnt;
  end

  // Stage 1: capture masked pulses with the current timestamp.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cap <= '0;
    else          cap <= '{mask: din & cfg_mask, ts: ts_ext};
  end

  // Stage 2: push non-empty snapshots; a same-cycle pop makes room when full.
  assign cap_hit   = |cap.mask;
  assign fifo_push = cap_hit & (~fifo_full | fifo_pop);
  assign drop      = cap_hit & fifo_full & ~fifo_pop;

  edge_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (cap),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Lowest-set-bit selection over the working snapshot.
  assign ch        = lowest_set(work.mask);
  assign work_clr  = work.mask & (work.mask - NUM_CH'(1));
  assign last_word = (work_clr == '0);

  // Serialiser state and working snapshot registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      work  <= '0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
    end
  end

  // Serialiser next state: load from the FIFO, strip one channel per handshake.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_nxt = state;
    work_nxt  = work;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          work_nxt  = fifo_head;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (m_axis_tready) begin
          if (!last_word) begin
            work_nxt.mask = work_clr;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            work_nxt = fifo_head;
          end else begin
            work_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_axis_tvalid = (state == EMIT);
  assign m_axis_tdata  = m_axis_tvalid ? pack_word(ch, work.ts) : '0;

`ifdef EDGE_EVENT_TLAST_EN
  assign m_axis_tlast = m_axis_tvalid & last_word;
`else
  assign m_axis_tlast = 1'b0;
`endif

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_overflow <= 1'b0;
      sts_drops    <= '0;
    end else if (drop) begin
      sts_overflow <= 1'b1;
      if (sts_drops != 16'hFFFF) sts_drops <= sts_drops + 16'd1;
    end
  end

endmodule

// File: tb/tb_edge_event_encoder.sv
// Directed bench for edge_event_encoder: table of single-snapshot vectors
// plus hand-written sequences for latency, stall/overflow, wrap and reset.
module tb_edge_event_encoder;

  logic        aclk     = 1'b0;
  logic        aresetn  = 1'b0;
  logic [64:0] din      = '0;
  logic [64:0] cfg_mask = '1;
  logic        tready   = 1'b1;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        sts_overflow;
  logic [15:0] sts_drops;

  logic [64:0] din4      = '0;
  logic [64:0] cfg_mask4 = '1;
  logic        tready4   = 1'b1;
  logic [63:0] tdata4;
  logic        tvalid4;
  logic        tlast4;
  logic        overflow4;
  logic [15:0] drops4;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned edges;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } word_t;

  typedef struct {
    string       name;
    logic [64:0] din;
    logic [64:0] mask;
    int          n;
    int          ch[3];
  } vec_t;

  word_t exp_q[$];
  vec_t  vecs[7];

  edge_event_encoder #(.TS_WIDTH(48), .FIFO_DEPTH(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .din           (din),
    .cfg_mask      (cfg_mask),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (m_axis_tlast),
    .sts_overflow  (sts_overflow),
    .sts_drops     (sts_drops)
  );

  edge_event_encoder #(.TS_WIDTH(4), .FIFO_DEPTH(16)) dut4 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .din           (din4),
    .cfg_mask      (cfg_mask4),
    .m_axis_tdata  (tdata4),
    .m_axis_tvalid (tvalid4),
    .m_axis_tready (tready4),
    .m_axis_tlast  (tlast4),
    .sts_overflow  (overflow4),
    .sts_drops     (drops4)
  );

  always #5 aclk = ~aclk;

  // Clock edges seen since reset release: the expected timestamp of the current cycle.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [63:0] word(input int ch, input logic [47:0] ts);
    logic [6:0] c;
    c = ch[6:0];
    return {1'b0, c, 8'h00, ts};
  endfunction

  function automatic logic exp_last(input bit is_last);
`ifdef EDGE_EVENT_TLAST_EN
    return is_last;
`else
    return 1'b0 & is_last;
`endif
  endfunction

  function automatic logic [64:0] oh(input int a, input int b, input int c);
    logic [64:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic expect_word(input int ch, input logic [47:0] ts, input bit is_last);
    word_t w;
    w.data = word(ch, ts);
    w.last = exp_last(is_last);
    exp_q.push_back(w);
  endtask

  task automatic set_vec(input int idx, input string name, input logic [64:0] d,
                         input logic [64:0] m, input int n, input int c0, input int c1,
                         input int c2);
    vecs[idx].name  = name;
    vecs[idx].din   = d;
    vecs[idx].mask  = m;
    vecs[idx].n     = n;
    vecs[idx].ch[0] = c0;
    vecs[idx].ch[1] = c1;
    vecs[idx].ch[2] = c2;
  endtask

  // Accept every word for 'budget' cycles, comparing against exp_q in order.
  task automatic drain(input string name, input bit use4, input int budget, output int span);
    int    first_c;
    int    last_c;
    word_t e;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < budget; c++) begin
      logic        v;
      logic [63:0] d;
      logic        l;
      if (!use4) tready = 1'b1;
      v = use4 ? tvalid4 : m_axis_tvalid;
      d = use4 ? tdata4  : m_axis_tdata;
      l = use4 ? tlast4  : m_axis_tlast;
      if (v) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_extra: unexpected word tdata=%0h", name, d);
        end else begin
          e = exp_q.pop_front();
          check({name, "_tdata"}, d, e.data);
          check({name, "_tlast"}, l, e.last);
        end
      end
      step();
    end
    check({name, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
    span = last_c - first_c;
  endtask

  initial begin
    int          span;
    int unsigned ts_a;
    int unsigned ts_x;
    int unsigned ts_c;
    int unsigned ts_q[17];

    set_vec(0, "single_ch5",     oh(5, -1, -1),  '1,             1, 5, 0, 0);
    set_vec(1, "tri_0_33_64",    oh(64, 0, 33),  '1,             3, 0, 33, 64);
    set_vec(2, "mask3_pair",     oh(3, 4, -1),   ~oh(3, -1, -1), 1, 4, 0, 0);
    set_vec(3, "mask3_solo",     oh(3, -1, -1),  ~oh(3, -1, -1), 0, 0, 0, 0);
    set_vec(4, "top_ch64",       oh(64, -1, -1), '1,             1, 64, 0, 0);
    set_vec(5, "pair_7_8",       oh(8, 7, -1),   '1,             2, 7, 8, 0);
    set_vec(6, "all_masked",     oh(1, 2, -1),   '0,             0, 0, 0, 0);

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid",   m_axis_tvalid, 0);
    check("rst_tlast",    m_axis_tlast, 0);
    check("rst_tdata",    m_axis_tdata, 0);
    check("rst_overflow", sts_overflow, 0);
    check("rst_drops",    sts_drops, 0);
    check("rst_tvalid4",  tvalid4, 0);
    aresetn = 1'b1;

    // 4-bit timestamp wraps from 15 to 0 with no flag.
    for (int i = 0; i < 40 && (edges % 16) != 15; i++) step();
    check("wrap_align", edges % 16, 15);
    din4 = oh(0, -1, -1);
    step();
    step();
    din4 = '0;
    expect_word(0, 48'd15, 1'b1);
    expect_word(0, 48'd0, 1'b1);
    drain("wrap", 1'b1, 10, span);
    check("wrap_overflow", overflow4, 0);
    check("wrap_drops",    drops4, 0);

    // Latency: pulse at counter 100 gives tvalid three cycles later.
    for (int i = 0; i < 200 && edges != 100; i++) step();
    check("lat_align", edges, 100);
    din = oh(5, -1, -1);
    step();
    din = '0;
    check("lat_c1_tvalid", m_axis_tvalid, 0);
    step();
    check("lat_c2_tvalid", m_axis_tvalid, 0);
    step();
    check("lat_c3_tvalid", m_axis_tvalid, 1);
    check("lat_c3_tdata",  m_axis_tdata, word(5, 48'd100));
    check("lat_c3_tlast",  m_axis_tlast, exp_last(1'b1));
    step();
    check("lat_c4_tvalid", m_axis_tvalid, 0);

    // Table: one snapshot per vector; mask is cleared right after capture.
    foreach (vecs[v]) begin
      cfg_mask = vecs[v].mask;
      ts_a = edges;
      din = vecs[v].din;
      for (int i = 0; i < vecs[v].n; i++) expect_word(vecs[v].ch[i], 48'(ts_a), i == vecs[v].n - 1);
      step();
      din = '0;
      cfg_mask = '0;
      drain(vecs[v].name, 1'b0, 10, span);
      if (vecs[v].n > 1) check({vecs[v].name, "_span"}, span, vecs[v].n - 1);
    end
    cfg_mask = '1;

    // Stall with a word held, then overflow the FIFO.
    tready = 1'b0;
    ts_a = edges;
    din = oh(2, -1, -1);
    step();
    din = '0;
    for (int i = 0; i < 10 && !m_axis_tvalid; i++) step();
    check("stall_tvalid", m_axis_tvalid, 1);
    for (int i = 0; i < 17; i++) begin
      ts_q[i] = edges;
      din = oh(1, -1, -1);
      check("stall_hold", m_axis_tdata, word(2, 48'(ts_a)));
      step();
    end
    din = '0;
    repeat (3) step();
    check("stall_hold_end", m_axis_tdata, word(2, 48'(ts_a)));
    check("ovf_flag",  sts_overflow, 1);
    check("ovf_drops", sts_drops, 1);

    // Push while full, same cycle as a pop: accepted, no new drop.
    ts_x = edges;
    din = oh(1, -1, -1);
    step();
    din = '0;
    tready = 1'b1;
    check("pushpop_tdata", m_axis_tdata, word(2, 48'(ts_a)));
    step();
    tready = 1'b0;
    repeat (2) step();
    check("pushpop_drops", sts_drops, 1);
    check("pushpop_head",  m_axis_tdata, word(1, 48'(ts_q[0])));
    for (int i = 0; i < 16; i++) expect_word(1, 48'(ts_q[i]), 1'b1);
    expect_word(1, 48'(ts_x), 1'b1);
    drain("after_stall", 1'b0, 25, span);
    check("after_stall_span", span, 16);

    // Reset in the middle of a multi-word snapshot with more queued.
    tready = 1'b0;
    din = oh(0, 33, 64);
    step();
    din = oh(7, -1, -1);
    step();
    din = '0;
    for (int i = 0; i < 10 && !m_axis_tvalid; i++) step();
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    check("pre_rst_ovf",    sts_overflow, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid",   m_axis_tvalid, 0);
    check("mid_rst_tlast",    m_axis_tlast, 0);
    check("mid_rst_tdata",    m_axis_tdata, 0);
    check("mid_rst_overflow", sts_overflow, 0);
    check("mid_rst_drops",    sts_drops, 0);
    step();
    aresetn = 1'b1;
    drain("post_rst_quiet", 1'b0, 10, span);
    ts_c = edges;
    din = oh(9, -1, -1);
    step();
    din = '0;
    expect_word(9, 48'(ts_c), 1'b1);
    drain("post_rst_word", 1'b0, 10, span);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
